// File: rtl/vlsu_addr_gen.sv
// Vector load/store address generator: expands one unit-stride or strided command
// into 64-bit beat requests toward the memory queue and reports completion.
module vlsu_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DW_B       = DATA_WIDTH >> 3,
  parameter int LEN_BITS   = 9,
  parameter int MAX_BEATS  = (1 << LEN_BITS) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_store,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic [LEN_BITS-1:0]   cmd_len,
  input  logic [DW_B-1:0]       cmd_be,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  st_valid,
  output logic                  st_ready,
  output logic [ADDR_WIDTH-1:0] q_addr,
  output logic                  q_req,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic                  q_valid,
  output logic                  q_start,
  output logic [DW_B-1:0]       q_be,
  output logic                  q_ready,
  input  logic                  q_done_ld,
  input  logic                  q_done_st,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int ALIGN_BITS = $clog2(DW_B);

  typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE, ST_WAIT} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] stride_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_BITS-1:0]   len_reg;
  logic [LEN_BITS-1:0]   cnt_reg;
  logic [DW_B-1:0]       be_reg;
  logic                  done_seen_reg;

  logic accept;
  logic illegal;
  logic last_beat;

  assign cmd_ready = (state_reg == IDLE);
  assign st_ready  = (state_reg == ST_ISSUE) && st_valid;
  assign accept    = cmd_valid && cmd_ready;
  // The length guard only bites when MAX_BEATS is overridden below the counter range.
  assign illegal   = (cmd_base[ALIGN_BITS-1:0] != '0) || (cmd_stride[ALIGN_BITS-1:0] != '0) ||
                     (cmd_len > LEN_BITS'(MAX_BEATS));
  assign last_beat = (cnt_reg == len_reg - LEN_BITS'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      stride_reg    <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      be_reg        <= '0;
      done_seen_reg <= 1'b0;
      q_addr        <= '0;
      q_req         <= 1'b0;
      q_data        <= '0;
      q_valid       <= 1'b0;
      q_start       <= 1'b0;
      q_be          <= '0;
      q_ready       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      q_req   <= 1'b0;
      q_valid <= 1'b0;
      q_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            stride_reg    <= cmd_stride;
            len_reg       <= cmd_len;
            be_reg        <= cmd_be;
            done_seen_reg <= 1'b0;
            if (illegal) begin
              err <= 1'b1;
            end else if (cmd_len == '0) begin
              done <= 1'b1;
            end else if (cmd_store) begin
              state_reg <= ST_ISSUE;
              busy      <= 1'b1;
              addr_reg  <= cmd_base;
              cnt_reg   <= '0;
            end else begin
              // Beat 0 is issued straight from the accept edge so loads have no dead cycle.
              q_req    <= 1'b1;
              q_addr   <= cmd_base;
              q_be     <= cmd_be;
              addr_reg <= cmd_base + cmd_stride;
              cnt_reg  <= LEN_BITS'(1);
              busy     <= 1'b1;
              if (cmd_len == LEN_BITS'(1)) begin
                state_reg <= LD_WAIT;
                q_ready   <= 1'b1;
              end else begin
                state_reg <= LD_ISSUE;
              end
            end
          end
        end
        LD_ISSUE: begin
          q_req    <= 1'b1;
          q_addr   <= addr_reg;
          addr_reg <= addr_reg + stride_reg;
          cnt_reg  <= cnt_reg + LEN_BITS'(1);
          if (q_done_ld) done_seen_reg <= 1'b1;
          if (last_beat) begin
            state_reg <= LD_WAIT;
            q_ready   <= 1'b1;
          end
        end
        LD_WAIT: begin
          if (q_done_ld || done_seen_reg) begin
            state_reg     <= IDLE;
            q_ready       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            done_seen_reg <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (q_done_st) done_seen_reg <= 1'b1;
          if (st_valid) begin
            q_valid  <= 1'b1;
            q_data   <= st_data;
            q_addr   <= addr_reg;
            q_be     <= be_reg;
            q_start  <= (cnt_reg == '0);
            addr_reg <= addr_reg + stride_reg;
            cnt_reg  <= cnt_reg + LEN_BITS'(1);
            if (last_beat) state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (q_done_st || done_seen_reg) begin
            state_reg     <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b1;
            done_seen_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vlsu_addr_gen.sv
// Randomised self-checking bench for vlsu_addr_gen; expected beats come from base + k*stride.
module tb_vlsu_addr_gen;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int LB = 9;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_store;
  logic [AW-1:0] cmd_base, cmd_stride;
  logic [LB-1:0] cmd_len;
  logic [BW-1:0] cmd_be;
  logic [DW-1:0] st_data;
  logic st_valid, st_ready;
  logic [AW-1:0] q_addr;
  logic q_req, q_valid, q_start, q_ready;
  logic [DW-1:0] q_data;
  logic [BW-1:0] q_be;
  logic q_done_ld, q_done_st, busy, done, err;
  logic [AW+DW+BW+6:0] outs;

  vlsu_addr_gen dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len), .cmd_be(cmd_be),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .q_addr(q_addr), .q_req(q_req),
    .q_data(q_data), .q_valid(q_valid), .q_start(q_start), .q_be(q_be), .q_ready(q_ready),
    .q_done_ld(q_done_ld), .q_done_st(q_done_st), .busy(busy), .done(done), .err(err)
  );

  assign outs = {q_addr, q_data, q_be, q_req, q_valid, q_start, q_ready, busy, done, err};

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor samples mid-cycle, away from the active edge.
  logic [AW-1:0] ld_addr_q[$];
  int            ld_cyc_q[$];
  logic [AW-1:0] st_addr_q[$];
  logic [DW-1:0] st_data_q[$];
  logic          st_start_q[$];
  logic [BW-1:0] st_be_q[$];
  logic [DW-1:0] exp_data_q[$];
  int mon_done_n, mon_err_n;

  always @(negedge clk) begin
    if (q_req) begin
      ld_addr_q.push_back(q_addr);
      ld_cyc_q.push_back(cyc);
    end
    if (q_valid) begin
      st_addr_q.push_back(q_addr);
      st_data_q.push_back(q_data);
      st_start_q.push_back(q_start);
      st_be_q.push_back(q_be);
    end
    if (done) mon_done_n++;
    if (err) mon_err_n++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon_clear();
    ld_addr_q.delete(); ld_cyc_q.delete();
    st_addr_q.delete(); st_data_q.delete(); st_start_q.delete(); st_be_q.delete();
    exp_data_q.delete();
    mon_done_n = 0;
    mon_err_n = 0;
  endtask

  task automatic send_cmd(input logic st, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input logic [LB-1:0] len, input logic [BW-1:0] be, output int acc);
    cmd_store = st; cmd_base = base; cmd_stride = stride; cmd_len = len; cmd_be = be;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    acc = cyc;
    $display("cmd %s base=%h stride=%h len=%0d be=%h accepted at cycle %0d",
             st ? "store" : "load", base, stride, len, be, acc);
  endtask

  task automatic pulse_ld();
    q_done_ld = 1'b1; tick(1); q_done_ld = 1'b0;
  endtask

  task automatic pulse_st();
    q_done_st = 1'b1; tick(1); q_done_st = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (q_ready) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  // Offers n store beats, using pat (LSB first) or random bubbles for the valid pattern.
  task automatic feed(input int n, input logic [31:0] pat, input bit rnd);
    int sent = 0;
    int i = 0;
    while (sent < n) begin
      logic v;
      v = rnd ? 1'($urandom_range(0, 1)) : ((i < 32) ? pat[i] : 1'b1);
      st_valid = v;
      st_data = {$urandom, $urandom};
      if (v) begin
        exp_data_q.push_back(st_data);
        sent++;
      end
      tick(1);
      i++;
    end
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; st_valid = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    checks++;
    if (st_ready !== 1'b0) begin failures++; $display("FAIL reset_st_ready got=%b want=0", st_ready); end
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h want=0", outs); end
    st_valid = 1'b0;
    tick(1);
  endtask

  task automatic test_load_basic();
    int acc; bit ok; logic [AW-1:0] e;
    mon_clear();
    send_cmd(1'b0, 32'h1000, 32'd8, 9'd4, 8'hFF, acc);
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL ld_busy got busy=%b cmd_ready=%b want 1/0", busy, cmd_ready);
    end
    wait_ready(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ld_wait_ready got q_ready=%b want 1 within 50 cycles", q_ready); end
    tick(10);
    checks++;
    if (q_ready !== 1'b1 || busy !== 1'b1 || mon_done_n != 0) begin
      failures++; $display("FAIL ld_hold got q_ready=%b busy=%b dones=%0d want 1/1/0", q_ready, busy, mon_done_n);
    end
    pulse_ld();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || q_ready !== 1'b0) begin
      failures++; $display("FAIL ld_done got done=%b busy=%b cmd_ready=%b q_ready=%b want 1/0/1/0",
                           done, busy, cmd_ready, q_ready);
    end
    tick(1);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL ld_done_pulse got done=%b want 0", done); end
    checks++;
    if (ld_addr_q.size() != 4) begin failures++; $display("FAIL ld_beats got=%0d want=4", ld_addr_q.size()); end
    for (int k = 0; k < ld_addr_q.size() && k < 4; k++) begin
      e = 32'h1000 + 32'(k) * 32'd8;
      checks++;
      if (ld_addr_q[k] !== e || ld_cyc_q[k] != acc + k) begin
        failures++; $display("FAIL ld_beat%0d got addr=%h cyc=%0d want addr=%h cyc=%0d",
                             k, ld_addr_q[k], ld_cyc_q[k], e, acc + k);
      end
    end
  endtask

  task automatic test_store_bubbles();
    int acc; logic [AW-1:0] e;
    mon_clear();
    send_cmd(1'b1, 32'h2000, 32'hFFFF_FFF0, 9'd3, 8'hFF, acc);
    feed(3, 32'b1101, 1'b0);
    st_valid = 1'b1;
    #1;
    checks++;
    if (st_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL st_wait got st_ready=%b busy=%b want 0/1", st_ready, busy);
    end
    st_valid = 1'b0;
    tick(3);
    pulse_st();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL st_done got done=%b busy=%b cmd_ready=%b want 1/0/1", done, busy, cmd_ready);
    end
    checks++;
    if (st_addr_q.size() != 3) begin failures++; $display("FAIL st_beats got=%0d want=3", st_addr_q.size()); end
    for (int k = 0; k < st_addr_q.size() && k < 3; k++) begin
      e = 32'h2000 - 32'(k) * 32'd16;
      checks++;
      if (st_addr_q[k] !== e || st_data_q[k] !== exp_data_q[k] || st_start_q[k] !== (k == 0) ||
          st_be_q[k] !== 8'hFF) begin
        failures++; $display("FAIL st_beat%0d got addr=%h data=%h start=%b be=%h want addr=%h data=%h start=%b be=ff",
                             k, st_addr_q[k], st_data_q[k], st_start_q[k], st_be_q[k], e, exp_data_q[k], k == 0);
      end
    end
    tick(1);
  endtask

  task automatic test_illegal_and_zero();
    int acc;
    mon_clear();
    send_cmd(1'b0, 32'h1004, 32'd8, 9'd4, 8'hFF, acc);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL illegal_base got err=%b busy=%b cmd_ready=%b done=%b want 1/0/1/0",
                           err, busy, cmd_ready, done);
    end
    tick(1);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL illegal_pulse got err=%b want 0", err); end
    send_cmd(1'b1, 32'h1000, 32'h0000_000C, 9'd2, 8'h0F, acc);
    checks++;
    if (err !== 1'b1 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL illegal_stride got err=%b cmd_ready=%b want 1/1", err, cmd_ready);
    end
    tick(1);
    send_cmd(1'b0, 32'h0100, 32'd8, 9'd0, 8'hFF, acc);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL len0 got done=%b err=%b busy=%b cmd_ready=%b want 1/0/0/1",
                           done, err, busy, cmd_ready);
    end
    tick(3);
    checks++;
    if (ld_addr_q.size() + st_addr_q.size() != 0 || mon_err_n != 2 || mon_done_n != 1) begin
      failures++; $display("FAIL illegal_no_req got reqs=%0d errs=%0d dones=%0d want 0/2/1",
                           ld_addr_q.size() + st_addr_q.size(), mon_err_n, mon_done_n);
    end
  endtask

  task automatic test_long_wrap();
    int acc; bit ok; logic [AW-1:0] e;
    mon_clear();
    send_cmd(1'b0, 32'hFFFF_FF00, 32'd8, 9'd511, 8'hFF, acc);
    tick(20);
    pulse_ld();
    wait_ready(600, ok);
    checks++;
    if (!ok || mon_done_n != 0) begin
      failures++; $display("FAIL long_ready got q_ready=%b dones=%0d want 1/0", q_ready, mon_done_n);
    end
    tick(1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL long_early_done got done=%b busy=%b want 1/0", done, busy);
    end
    checks++;
    if (ld_addr_q.size() != 511) begin failures++; $display("FAIL long_beats got=%0d want=511", ld_addr_q.size()); end
    for (int k = 0; k < ld_addr_q.size() && k < 511; k++) begin
      e = 32'hFFFF_FF00 + 32'(k) * 32'd8;
      checks++;
      if (ld_addr_q[k] !== e || ld_cyc_q[k] != acc + k) begin
        failures++; $display("FAIL long_beat%0d got addr=%h cyc=%0d want addr=%h cyc=%0d",
                             k, ld_addr_q[k], ld_cyc_q[k], e, acc + k);
      end
    end
    tick(1);
  endtask

  task automatic test_reset_mid_store();
    int acc; bit ok; logic [AW-1:0] e;
    mon_clear();
    send_cmd(1'b1, 32'h3000, 32'd8, 9'd5, 8'h3C, acc);
    feed(2, 32'hFFFF_FFFF, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (outs !== '0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_outputs got outs=%h cmd_ready=%b want 0/1", outs, cmd_ready);
    end
    tick(4);
    checks++;
    if (mon_done_n != 0 || st_addr_q.size() != 2) begin
      failures++; $display("FAIL midrst_no_done got dones=%0d st_beats=%0d want 0/2", mon_done_n, st_addr_q.size());
    end
    mon_clear();
    send_cmd(1'b0, 32'h4000, 32'h18, 9'd3, 8'hFF, acc);
    wait_ready(20, ok);
    pulse_ld();
    checks++;
    if (!ok || done !== 1'b1) begin failures++; $display("FAIL midrst_load_done got ready=%b done=%b want 1/1", ok, done); end
    checks++;
    if (ld_addr_q.size() != 3) begin failures++; $display("FAIL midrst_beats got=%0d want=3", ld_addr_q.size()); end
    for (int k = 0; k < ld_addr_q.size() && k < 3; k++) begin
      e = 32'h4000 + 32'(k) * 32'h18;
      checks++;
      if (ld_addr_q[k] !== e) begin failures++; $display("FAIL midrst_beat%0d got=%h want=%h", k, ld_addr_q[k], e); end
    end
    tick(1);
  endtask

  task automatic test_stray_done();
    int acc; bit ok;
    mon_clear();
    pulse_ld();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL stray_idle got done=%b cmd_ready=%b want 0/1", done, cmd_ready);
    end
    send_cmd(1'b0, 32'h0500, 32'd0, 9'd6, 8'hFF, acc);
    tick(1);
    pulse_st();
    wait_ready(20, ok);
    tick(3);
    pulse_st();
    tick(3);
    checks++;
    if (!ok || mon_done_n != 0 || busy !== 1'b1) begin
      failures++; $display("FAIL stray_ignored got ready=%b dones=%0d busy=%b want 1/0/1", ok, mon_done_n, busy);
    end
    pulse_ld();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL stray_done got done=%b busy=%b want 1/0", done, busy); end
    checks++;
    if (ld_addr_q.size() != 6) begin failures++; $display("FAIL stride0_beats got=%0d want=6", ld_addr_q.size()); end
    for (int k = 0; k < ld_addr_q.size() && k < 6; k++) begin
      checks++;
      if (ld_addr_q[k] !== 32'h0500) begin failures++; $display("FAIL stride0_beat%0d got=%h want=00000500", k, ld_addr_q[k]); end
    end
    tick(1);
  endtask

  task automatic test_random();
    int acc; bit ok; bit early; int n;
    logic st; logic [AW-1:0] base, stride, e; logic [LB-1:0] len; logic [BW-1:0] be;
    for (int t = 0; t < 12; t++) begin
      mon_clear();
      st = 1'($urandom_range(0, 1));
      base = $urandom & 32'hFFFF_FFF8;
      stride = ($urandom_range(0, 1) != 0) ? (32'($urandom_range(0, 64)) << 3) : (32'hFFFF_FF00 | ($urandom & 32'hF8));
      len = 9'($urandom_range(1, 20));
      be = 8'($urandom);
      early = (!st) && (len >= 9'd3) && ($urandom_range(0, 1) != 0);
      send_cmd(st, base, stride, len, be, acc);
      if (st) begin
        feed(int'(len), 32'h0, 1'b1);
        tick($urandom_range(0, 5));
        pulse_st();
      end else begin
        if (early) begin
          tick(1);
          pulse_ld();
        end
        wait_ready(40, ok);
        if (early) tick(1);
        else begin
          tick($urandom_range(0, 5));
          pulse_ld();
        end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL rand%0d_done got done=%b busy=%b want 1/0", t, done, busy);
      end
      n = st ? st_addr_q.size() : ld_addr_q.size();
      checks++;
      if (n != int'(len) || (st ? ld_addr_q.size() : st_addr_q.size()) != 0) begin
        failures++; $display("FAIL rand%0d_beats got=%0d want=%0d", t, n, len);
      end
      for (int k = 0; k < n && k < int'(len); k++) begin
        e = base + 32'(k) * stride;
        checks++;
        if (st ? (st_addr_q[k] !== e || st_data_q[k] !== exp_data_q[k] || st_be_q[k] !== be ||
                  st_start_q[k] !== (k == 0))
               : (ld_addr_q[k] !== e || ld_cyc_q[k] != acc + k)) begin
          failures++; $display("FAIL rand%0d_beat%0d got addr=%h want addr=%h", t, k,
                               st ? st_addr_q[k] : ld_addr_q[k], e);
        end
      end
      tick(1);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0; cmd_stride = '0;
    cmd_len = '0; cmd_be = '0; st_data = '0; st_valid = 1'b0; q_done_ld = 1'b0; q_done_st = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_basic();
    test_store_bubbles();
    test_illegal_and_zero();
    test_long_wrap();
    test_reset_mid_store();
    test_stray_done();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vlsu_addr_gen.md
Name: vlsu_addr_gen

Overview:
- Upstream stage of the vector memory queue.
- Accepts one unit-stride or strided vector load/store command at a time from the vector core and expands it into a sequence of 64-bit beat requests.
- Load: drives one address request per beat. Store: pairs each address with store data from the vector register file.
- Holds the command busy until the queue's done_ld/done_st arrives, then reports completion to the core.

Parameters:
ADDR_WIDTH, 32, byte address width (matches MBUS_ADDR_WIDTH)
DATA_WIDTH, 64, beat width (matches RVV_DATA_WIDTH)
DW_B, DATA_WIDTH>>3, bytes per beat
LEN_BITS, 9, beat-count width; equals queue FIFO_DEPTH_BITS
MAX_BEATS, (1<<LEN_BITS)-1, largest legal command length

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block accepts command (high only in IDLE)
cmd_store  in  1  1=store, 0=load
cmd_base  in  ADDR_WIDTH  first beat byte address
cmd_stride  in  ADDR_WIDTH  signed byte stride between beats
cmd_len  in  LEN_BITS  number of beats
cmd_be  in  DW_B  byte enable for every beat
st_data  in  DATA_WIDTH  store beat from VRF
st_valid  in  1  st_data valid
st_ready  out  1  st_data consumed this cycle
q_addr  out  ADDR_WIDTH  beat address to queue
q_req  out  1  load address request strobe
q_data  out  DATA_WIDTH  store beat to queue
q_valid  out  1  store beat strobe
q_start  out  1  first store beat of command
q_be  out  DW_B  byte enables
q_ready  out  1  core can accept load return data (held high in LD_WAIT)
q_done_ld  in  1  queue load completion pulse
q_done_st  in  1  queue store completion pulse
busy  out  1  command in flight
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse: command rejected

Behaviour:
- Reset (rst high at a clock edge, any state): state=IDLE.
  - All outputs are 0 except cmd_ready=1.
  - Counters and latched command registers are cleared.
  - An in-flight command is abandoned and no done is issued.
- All outputs are registered except cmd_ready and st_ready, which are decoded from state and inputs.
- States: IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE, ST_WAIT.
- IDLE: accept on cmd_valid & cmd_ready and latch all cmd_* fields.
  - Illegal command (cmd_base[2:0]!=0 or cmd_stride[2:0]!=0): err pulses the next cycle, stay IDLE, no requests.
  - cmd_len==0: done pulses the next cycle, stay IDLE, no requests.
  - Otherwise go to LD_ISSUE or ST_ISSUE; busy=1 from the next cycle until the cycle done is asserted.
- LD_ISSUE: one beat per cycle, with no backpressure.
  - Each beat asserts q_req=1 and q_addr=base+k*stride, k=0..len-1.
  - Address math is modulo 2^ADDR_WIDTH; wrap-around is allowed and not flagged.
  - After beat len-1, go to LD_WAIT.
  - First q_req appears 1 cycle after acceptance; last appears at acceptance+len cycles.
  - q_req beats are contiguous.
- LD_WAIT: q_ready=1.
  - On q_done_ld, go to IDLE and pulse done in the same cycle busy falls.
  - q_done_ld arriving during LD_ISSUE is latched and honoured on entry to LD_WAIT.
- ST_ISSUE: st_ready = st_valid (beat consumed whenever offered).
  - A consumed beat registers q_valid=1 with q_data=st_data, q_addr=base+k*stride, q_be=cmd_be.
  - q_start=1 only on k=0.
  - Cycles with st_valid=0 produce q_valid=0 and do not advance k; bubbles are permitted.
  - After beat len-1 is consumed, go to ST_WAIT.
- ST_WAIT: on q_done_st, go to IDLE with a done pulse. q_done_st is latched early as for loads.
- q_done_* pulses received in IDLE, or of the wrong kind for the current command, are ignored.
- Beat counter is LEN_BITS wide; len=MAX_BEATS is legal and must issue exactly MAX_BEATS beats.
- Stride 0 is legal: the same address is repeated len times.
- Negative stride uses two's-complement addition.
- cmd_valid while busy is not accepted; the offering side holds it.

Test Plan:
- Load base=0x1000, stride=8, len=4 → q_req high 4 consecutive cycles with q_addr 0x1000,0x1008,0x1010,0x1018; q_ready=1 in LD_WAIT; q_done_ld 10 cycles later → done pulse, busy low, cmd_ready high.
- Store base=0x2000, stride=-16, len=3, be=0xFF, st_valid toggling 1,0,1,1 → q_valid on 3 beats at 0x2000,0x1FF0,0x1FE0; q_start only on first; data matches in order; q_done_st → done.
- Illegal base=0x1004 → err pulse, no q_req/q_valid, remains IDLE; len=0 → done next cycle, no requests.
- len=511, stride=8, base=0xFFFF_FF00 → exactly 511 q_req, addresses wrap past 0xFFFF_FFF8 to 0x0000_0000; early q_done_ld during issue still yields done after last beat.
- rst asserted mid-ST_ISSUE after 2 beats → next cycle all outputs 0, cmd_ready=1, no done; a subsequent load executes normally from k=0.
- Stray q_done_st during a load and q_done_ld in IDLE → ignored; the load completes only on its own q_done_ld.
